// File: rtl/pixel_frame_loader_pkg.sv
// Shared definitions for the pixel frame loader: control states, frame size
// and the width of the neuron result.
package pixel_frame_loader_pkg;

  localparam int NUM_PIXELS = 9;
  localparam int DATA_W     = 20;
  localparam int IDX_W      = 4;
  localparam int SETTLE_W   = 4;
  localparam int GAP_W      = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_frame_loader.sv
// Pixel frame loader: shifts nine serial pixels into a 3x3 frame X_0..X_8,
// holds the frame steady for SETTLE_CYCLES so the external neuron output
// D_in can settle, registers that result on D_out and offers it with a
// valid/ready handshake.
// Optional feature (macro LOAD_TIMEOUT_EN): a partial frame whose pixels stop
// arriving for TIMEOUT_CYCLES cycles is dropped, the pixel index rewinds to 0
// and frame_dropped pulses for one cycle. Without the macro, frame_dropped is
// tied to 0 and a partial frame waits indefinitely.
module pixel_frame_loader
  import pixel_frame_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     X_0,
  output logic                     X_1,
  output logic                     X_2,
  output logic                     X_3,
  output logic                     X_4,
  output logic                     X_5,
  output logic                     X_6,
  output logic                     X_7,
  output logic                     X_8,
  input  logic signed [DATA_W-1:0] D_in,
  output logic signed [DATA_W-1:0] D_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_dropped
);

  // Parameter legality, caught at elaboration
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("pixel_frame_loader: SETTLE_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("pixel_frame_loader: TIMEOUT_CYCLES must be in 2..255");
  end

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_PIXELS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_PIXELS-1:0]     x_q, x_d;
  logic [SETTLE_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic signed [DATA_W-1:0]  d_out_q, d_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      accept;

  assign pix_ready = (state_q == LOAD);
  assign accept    = pix_valid && pix_ready;

  assign X_0 = x_q[0];
  assign X_1 = x_q[1];
  assign X_2 = x_q[2];
  assign X_3 = x_q[3];
  assign X_4 = x_q[4];
  assign X_5 = x_q[5];
  assign X_6 = x_q[6];
  assign X_7 = x_q[7];
  assign X_8 = x_q[8];

  assign D_out     = d_out_q;
  assign out_valid = out_valid_q;

`ifdef LOAD_TIMEOUT_EN
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             frame_dropped_q, frame_dropped_d;

  assign frame_dropped = frame_dropped_q;
`else
  assign frame_dropped = 1'b0;
`endif

  // Next-state logic: pixel capture, settle timing, result handshake
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x_d          = x_q;
    settle_cnt_d = settle_cnt_q;
    d_out_d      = d_out_q;
    out_valid_d  = out_valid_q;
`ifdef LOAD_TIMEOUT_EN
    gap_cnt_d       = '0;
    frame_dropped_d = 1'b0;
`endif

    case (state_q)
      LOAD: begin
        if (accept) begin
          for (int k = 0; k < NUM_PIXELS; k++) begin
            if (idx_q == IDX_W'(k)) x_d[k] = pix_in;
          end
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`ifdef LOAD_TIMEOUT_EN
        // The gap only runs while a frame is partially loaded; X is kept on a drop
        else if (idx_q != '0) begin
          if (gap_cnt_q == GAP_LAST) begin
            idx_d           = '0;
            frame_dropped_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
`endif
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          d_out_d      = D_in;
          out_valid_d  = 1'b1;
          settle_cnt_d = '0;
          state_d      = OUT;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end

      default: begin
        state_d     = LOAD;
        idx_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset discards any partial frame or pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      x_q          <= '0;
      settle_cnt_q <= '0;
      d_out_q      <= '0;
      out_valid_q  <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      gap_cnt_q       <= '0;
      frame_dropped_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      x_q          <= x_d;
      settle_cnt_q <= settle_cnt_d;
      d_out_q      <= d_out_d;
      out_valid_q  <= out_valid_d;
`ifdef LOAD_TIMEOUT_EN
      gap_cnt_q       <= gap_cnt_d;
      frame_dropped_q <= frame_dropped_d;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Self-checking bench for pixel_frame_loader: randomized frames checked
// against a frame-level model (expected X contents and result timing), plus
// a second instance with SETTLE_CYCLES = 3 for the settle-window capture.
module tb_pixel_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance with SETTLE_CYCLES = 1
  logic pix_in, pix_valid, pix_ready, out_ready, out_valid, frame_dropped;
  logic x0, x1, x2, x3, x4, x5, x6, x7, x8;
  logic signed [19:0] d_in, d_out;

  // Instance with SETTLE_CYCLES = 3
  logic pix_in3, pix_valid3, pix_ready3, out_ready3, out_valid3, frame_dropped3;
  logic y0, y1, y2, y3, y4, y5, y6, y7, y8;
  logic signed [19:0] d_in3, d_out3;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] exp_x;
  logic [8:0] exp_x3;

  pixel_frame_loader #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .X_0(x0), .X_1(x1), .X_2(x2), .X_3(x3), .X_4(x4),
    .X_5(x5), .X_6(x6), .X_7(x7), .X_8(x8),
    .D_in(d_in), .D_out(d_out), .out_valid(out_valid), .out_ready(out_ready),
    .frame_dropped(frame_dropped)
  );

  pixel_frame_loader #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(16)) u_dut3 (
    .clk(clk), .rst(rst), .pix_in(pix_in3), .pix_valid(pix_valid3),
    .pix_ready(pix_ready3),
    .X_0(y0), .X_1(y1), .X_2(y2), .X_3(y3), .X_4(y4),
    .X_5(y5), .X_6(y6), .X_7(y7), .X_8(y8),
    .D_in(d_in3), .D_out(d_out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .frame_dropped(frame_dropped3)
  );

  function automatic logic [8:0] xv();
    return {x8, x7, x6, x5, x4, x3, x2, x1, x0};
  endfunction

  function automatic logic [8:0] xv3();
    return {y8, y7, y6, y5, y4, y3, y2, y1, y0};
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed n pixels of bits (bit k goes to X_k); gap_mode < 0 gives random
  // idle gaps of 0..2 cycles, otherwise a fixed gap before each pixel.
  task automatic load_pixels(input logic [8:0] bits, input int n, input int gap_mode);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
      for (int g = 0; g < gap; g++) begin
        pix_valid = 1'b0;
        pix_in    = 1'($urandom);
        tick();
        check_eq("gap_pix_ready", int'(pix_ready), 1);
        check_eq("gap_x", int'(xv()), int'(exp_x));
        check_eq("gap_frame_dropped", int'(frame_dropped), 0);
      end
      pix_valid = 1'b1;
      pix_in    = bits[k];
      tick();
      exp_x[k] = bits[k];
      check_eq("load_x", int'(xv()), int'(exp_x));
      check_eq("load_out_valid", int'(out_valid), 0);
      check_eq("load_pix_ready", int'(pix_ready), (k == 8) ? 0 : 1);
    end
    pix_valid = 1'b0;
  endtask

  // Full frame; ends sampled in the single SETTLE cycle with D_in driven
  task automatic load_frame(input logic [8:0] bits, input int gap_mode,
                            input logic signed [19:0] dval);
    load_pixels(bits, 9, gap_mode);
    check_eq("settle_out_valid", int'(out_valid), 0);
    d_in = dval;
  endtask

  // Result appears one cycle after SETTLE, held for `hold` stalled cycles
  task automatic expect_result(input logic signed [19:0] dval, input int hold);
    out_ready = 1'b0;
    tick();
    check_eq("out_valid_rise", int'(out_valid), 1);
    check_eq("d_out", int'(d_out), int'(dval));
    check_eq("out_pix_ready", int'(pix_ready), 0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      d_in      = (h == 0) ? -20'sd7 : 20'($urandom);
      pix_valid = 1'($urandom);
      pix_in    = 1'($urandom);
      tick();
      check_eq("hold_out_valid", int'(out_valid), 1);
      check_eq("hold_d_out", int'(d_out), int'(dval));
      check_eq("hold_pix_ready", int'(pix_ready), 0);
      check_eq("hold_x", int'(xv()), int'(exp_x));
    end
    // Handshake cycle also presents a pixel that must not be taken
    out_ready = 1'b1;
    pix_valid = 1'b1;
    pix_in    = ~exp_x[0];
    tick();
    pix_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("post_hs_out_valid", int'(out_valid), 0);
    check_eq("post_hs_pix_ready", int'(pix_ready), 1);
    check_eq("post_hs_x", int'(xv()), int'(exp_x));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_x", int'(xv()), 0);
    check_eq("rst_d_out", int'(d_out), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_frame_dropped", int'(frame_dropped), 0);
    check_eq("rst_pix_ready", int'(pix_ready), 1);
    check_eq("rst_x3", int'(xv3()), 0);
    check_eq("rst_out_valid3", int'(out_valid3), 0);
  endtask

  initial begin
    logic [8:0]         bits;
    logic signed [19:0] dval;
    logic signed [19:0] v1, v2, v3;
    int                 drops;

    rst = 1'b1;
    pix_in = 1'b0; pix_valid = 1'b0; out_ready = 1'b0; d_in = '0;
    pix_in3 = 1'b0; pix_valid3 = 1'b0; out_ready3 = 1'b0; d_in3 = '0;
    exp_x  = '0;
    exp_x3 = '0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Alternating pattern, back-to-back, result taken immediately
    load_frame(9'b1_0101_0101, 0, 20'sd1234);
    expect_result(20'sd1234, 0);

    // Stalled consumer while D_in moves and pixels are offered
    load_frame(9'b0_1100_1011, 0, 20'sd1234);
    expect_result(20'sd1234, 5);

    // pix_valid every other cycle
    load_frame(9'b1_1110_0001, 1, -20'sd99);
    expect_result(-20'sd99, 2);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      bits = 9'($urandom);
      dval = 20'($urandom);
      load_frame(bits, -1, dval);
      expect_result(dval, int'($urandom_range(0, 4)));
    end

    // Reset in the middle of a frame
    load_pixels(9'($urandom), 5, 0);
    #2 rst = 1'b1;
    #1;
    exp_x = '0;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Reset while a result is pending
    load_frame(9'b1_1111_1111, 0, 20'sd555);
    tick();
    check_eq("pend_out_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    exp_x = '0;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_no_valid", int'(out_valid), 0);
    end

    // A clean frame afterwards gives exactly one result
    bits = 9'($urandom);
    load_frame(bits, 0, 20'sd321);
    expect_result(20'sd321, 0);
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      drops += int'(out_valid);
    end
    check_eq("single_result", drops, 0);

`ifdef LOAD_TIMEOUT_EN
    // Stalled partial frame is dropped once; next frame restarts at X_0
    load_pixels(9'b0_0000_1111, 4, 0);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1'b0;
      tick();
      drops += int'(frame_dropped);
    end
    check_eq("timeout_drop_count", drops, 1);
    check_eq("timeout_x_kept", int'(xv()), int'(exp_x));
    load_frame(9'b1_0000_0000, 0, 20'sd77);
    expect_result(20'sd77, 0);
`endif

    // SETTLE_CYCLES = 3: D_in captured on the last settle cycle
    bits = 9'($urandom);
    for (int k = 0; k < 9; k++) begin
      pix_valid3 = 1'b1;
      pix_in3    = bits[k];
      tick();
      exp_x3[k] = bits[k];
      check_eq("s3_load_x", int'(xv3()), int'(exp_x3));
    end
    pix_valid3 = 1'b0;
    v1 = 20'sd100;
    v2 = -20'sd200;
    v3 = 20'sd300;
    d_in3 = v1;
    check_eq("s3_settle1_valid", int'(out_valid3), 0);
    tick();
    d_in3 = v2;
    check_eq("s3_settle2_valid", int'(out_valid3), 0);
    tick();
    d_in3 = v3;
    check_eq("s3_settle3_valid", int'(out_valid3), 0);
    check_eq("s3_settle3_ready", int'(pix_ready3), 0);
    tick();
    d_in3 = 20'sd9;
    check_eq("s3_out_valid", int'(out_valid3), 1);
    check_eq("s3_d_out", int'(d_out3), int'(v3));
    check_eq("s3_x_stable", int'(xv3()), int'(exp_x3));
    out_ready3 = 1'b1;
    tick();
    out_ready3 = 1'b0;
    check_eq("s3_post_hs_valid", int'(out_valid3), 0);
    check_eq("s3_frame_dropped", int'(frame_dropped3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
